cache_miss_controller: RTL

- Sequences a direct-mapped, read-only byte cache sitting between the CPU-side byte-read port and the word-wide RAM/ROM.
- Owns tag/valid/data arrays, performs lookup, and issues word fetches to memory on a miss with req/ack handshake and timeout.
- Fills the line and returns the selected byte.
- Also provides flush and hit/miss statistics for the lab datapath.

---
 rtl/cache_miss_controller.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_miss_controller.sv
// Direct-mapped read-only byte cache controller: lookup, single-word line fill
// over a req/ack memory port with timeout, flush, and saturating hit/miss counters.
module cache_miss_controller #(
    parameter int ADDR_W  = 8,
    parameter int INDEX_W = 2,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cpu_req_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    output logic              cpu_ready_o,
    output logic              cpu_valid_o,
    output logic              cpu_hit_o,
    output logic              cpu_err_o,
    output logic [7:0]        cpu_rdata_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-3:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    localparam int TAG_W = ADDR_W - 2 - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOOKUP   = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_FLUSH    = 2'd3
    } state_t;

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] off);
        logic [7:0] b;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] r;
        if (&cnt) begin
            r = cnt;
        end else begin
            r = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [31:0]        data_q [LINES];
    logic [7:0]         tcnt_q, tcnt_d;
    logic               mem_req_q, mem_req_d;
    logic               cpu_valid_q, cpu_valid_d;
    logic               cpu_hit_q, cpu_hit_d;
    logic               cpu_err_q, cpu_err_d;
    logic [7:0]         cpu_rdata_q, cpu_rdata_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    logic [INDEX_W-1:0] idx_s;
    logic [TAG_W-1:0]   tag_s;
    logic [1:0]         off_s;
    logic               lookup_hit_s;
    logic               timeout_s;
    logic               fill_s;

    assign idx_s        = addr_q[INDEX_W+1:2];
    assign tag_s        = addr_q[ADDR_W-1:INDEX_W+2];
    assign off_s        = addr_q[1:0];
    assign lookup_hit_s = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
    // The wait cycle that would bring the counter to TIMEOUT is the abort cycle.
    assign timeout_s    = (({1'b0, tcnt_q} + 9'd1) == 9'(TIMEOUT));

    assign cpu_ready_o  = (state_q == S_IDLE) && !flush_i;
    assign cpu_valid_o  = cpu_valid_q;
    assign cpu_hit_o    = cpu_hit_q;
    assign cpu_err_o    = cpu_err_q;
    assign cpu_rdata_o  = cpu_rdata_q;
    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = addr_q[ADDR_W-1:2];
    assign hit_cnt_o    = hit_cnt_q;
    assign miss_cnt_o   = miss_cnt_q;

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; flush outranks a simultaneous request in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (flush_i) begin
                    state_d = S_FLUSH;
                end else if (cpu_req_i) begin
                    state_d = S_LOOKUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOOKUP: begin
                if (lookup_hit_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                if (mem_ack_i || timeout_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_MEM_WAIT;
                end
            end
            S_FLUSH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; an ack in the timeout cycle still fills.
    always_comb begin
        addr_d      = addr_q;
        valid_d     = valid_q;
        tcnt_d      = tcnt_q;
        mem_req_d   = mem_req_q;
        cpu_valid_d = 1'b0;
        cpu_hit_d   = 1'b0;
        cpu_err_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        fill_s      = 1'b0;
        case (state_q)
            S_IDLE: begin
                mem_req_d = 1'b0;
                if (!flush_i && cpu_req_i) begin
                    addr_d = cpu_addr_i;
                end else begin
                    addr_d = addr_q;
                end
            end
            S_LOOKUP: begin
                if (lookup_hit_s) begin
                    cpu_valid_d = 1'b1;
                    cpu_hit_d   = 1'b1;
                    cpu_rdata_d = byte_sel(data_q[idx_s], off_s);
                    hit_cnt_d   = sat_inc(hit_cnt_q);
                end else begin
                    mem_req_d = 1'b1;
                    tcnt_d    = 8'd0;
                end
            end
            S_MEM_WAIT: begin
                if (mem_ack_i) begin
                    fill_s         = 1'b1;
                    valid_d[idx_s] = 1'b1;
                    mem_req_d      = 1'b0;
                    cpu_valid_d    = 1'b1;
                    cpu_rdata_d    = byte_sel(mem_rdata_i, off_s);
                    miss_cnt_d     = sat_inc(miss_cnt_q);
                end else if (timeout_s) begin
                    mem_req_d   = 1'b0;
                    cpu_valid_d = 1'b1;
                    cpu_err_d   = 1'b1;
                    cpu_rdata_d = 8'h00;
                    miss_cnt_d  = sat_inc(miss_cnt_q);
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            S_FLUSH: begin
                valid_d = {LINES{1'b0}};
            end
            default: begin
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Control, response and statistics registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            addr_q      <= {ADDR_W{1'b0}};
            valid_q     <= {LINES{1'b0}};
            tcnt_q      <= 8'd0;
            mem_req_q   <= 1'b0;
            cpu_valid_q <= 1'b0;
            cpu_hit_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            cpu_rdata_q <= 8'h00;
            hit_cnt_q   <= {CNT_W{1'b0}};
            miss_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            tcnt_q      <= tcnt_d;
            mem_req_q   <= mem_req_d;
            cpu_valid_q <= cpu_valid_d;
            cpu_hit_q   <= cpu_hit_d;
            cpu_err_q   <= cpu_err_d;
            cpu_rdata_q <= cpu_rdata_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Tag and data storage, written only on an acknowledged fill.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < LINES; i++) begin
                tag_q[i]  <= {TAG_W{1'b0}};
                data_q[i] <= 32'h0000_0000;
            end
        end else if (fill_s) begin
            tag_q[idx_s]  <= tag_s;
            data_q[idx_s] <= mem_rdata_i;
        end else begin
            tag_q  <= tag_q;
            data_q <= data_q;
        end
    end

endmodule
